// File: rtl/spi_pkg.sv
// Shared constants and types for the 16-bit SPI responder.
package spi_pkg;
   localparam int FRAME_BITS  = 16;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 5;

   typedef enum logic {IDLE, SHIFT} spi_slv_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous pin into the clk domain and flags its edges.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic sync,
   output logic rise,
   output logic fall
);

   // SYNC_STAGES metastability flops followed by one edge-history flop
   logic [SYNC_STAGES:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ff <= {(SYNC_STAGES + 1){RST_VAL}};
      else
         ff <= {ff[SYNC_STAGES-1:0], d};
   end

   assign sync = ff[SYNC_STAGES-1];
   assign rise = ff[SYNC_STAGES-1] & ~ff[SYNC_STAGES];
   assign fall = ~ff[SYNC_STAGES-1] & ff[SYNC_STAGES];

endmodule

// File: rtl/spi_slv16.sv
// Mode-0 SPI responder: shifts a preloaded word out on MISO, captures a 16-bit command.
//  state | meaning
//  IDLE  | SS_n high or frame not yet started; SCLK ignored, MISO released
//  SHIFT | frame in progress; count SCLK rises, shift on falls
module spi_slv16
   import spi_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SS_n,
   input  logic                  SCLK,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [FRAME_BITS-1:0] tx_data,
   input  logic                  wrt,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  cmd_rdy,
   output logic                  frm_err
);

   localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   spi_slv_state_t        state, nxt_state;
   logic                  ss_sync, ss_rise, ss_fall;
   logic                  unused_sclk_lvl, sclk_rise, sclk_fall;
   logic                  mosi_ff1, mosi_ff2, mosi_smpl;
   logic [FRAME_BITS-1:0] shft_reg, tx_buf;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  load, fin;

   spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (SS_n),
      .sync (ss_sync),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (SCLK),
      .sync (unused_sclk_lvl),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   // Two stages only, so the sampled bit lines up with the sclk_rise pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mosi_ff1 <= 1'b0;
         mosi_ff2 <= 1'b0;
      end else begin
         mosi_ff1 <= MOSI;
         mosi_ff2 <= mosi_ff1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      load      = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               nxt_state = SHIFT;
               load      = 1'b1;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               nxt_state = IDLE;
               fin       = 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shft_reg  <= '0;
         tx_buf    <= '0;
         rx_data   <= '0;
         mosi_smpl <= 1'b0;
         bit_cnt   <= '0;
         cmd_rdy   <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         cmd_rdy <= 1'b0;
         frm_err <= 1'b0;
         if (wrt)
            tx_buf <= tx_data;
         if (load) begin
            shft_reg <= wrt ? tx_data : tx_buf;
            bit_cnt  <= '0;
         end else if (state == SHIFT) begin
            if (sclk_rise) begin
               mosi_smpl <= mosi_ff2;
               if (bit_cnt != CNT_MAX)
                  bit_cnt <= bit_cnt + 1'b1;
            end
            // the front-porch fall (count still 0) must not shift
            if (sclk_fall && (bit_cnt != '0) && (bit_cnt < CNT_FRAME))
               shft_reg <= {shft_reg[FRAME_BITS-2:0], mosi_smpl};
            if (fin) begin
               if (bit_cnt == CNT_FRAME) begin
                  rx_data <= {shft_reg[FRAME_BITS-2:0], mosi_smpl};
                  cmd_rdy <= 1'b1;
               end else begin
                  frm_err <= 1'b1;
               end
            end
         end
      end
   end

   assign MISO = ((state == SHIFT) && !ss_sync) ? shft_reg[FRAME_BITS-1] : 1'bz;

endmodule

// File: tb/tb_spi_slv16.sv
// Scoreboard bench for spi_slv16: bench-side SPI master plus a word-level reference model.
module tb_spi_slv16;
   import spi_pkg::*;

   typedef struct {
      bit          err;
      logic [15:0] rx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, ss_n, sclk, mosi, wrt;
   logic [15:0] tx_data;
   wire         miso;
   logic [15:0] rx_data;
   logic        cmd_rdy, frm_err;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // reference model: word the next frame returns, and last good command
   logic [15:0] tx_model, rx_model;

   spi_slv16 dut (
      .clk     (clk),
      .rst     (rst),
      .SS_n    (ss_n),
      .SCLK    (sclk),
      .MOSI    (mosi),
      .MISO    (miso),
      .tx_data (tx_data),
      .wrt     (wrt),
      .rx_data (rx_data),
      .cmd_rdy (cmd_rdy),
      .frm_err (frm_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tx(input logic [15:0] v);
      @(negedge clk);
      tx_data = v;
      wrt     = 1'b1;
      @(negedge clk);
      wrt      = 1'b0;
      tx_model = v;
   endtask

   task automatic frame(input logic [15:0] cmd, input int n, input bit mid,
                        input logic [15:0] mid_val, input bit byp, input logic [15:0] byp_val);
      logic [15:0] resp, got;
      exp_t        e;
      got  = '0;
      resp = byp ? byp_val : tx_model;
      if (byp) tx_model = byp_val;
      @(negedge clk);
      ss_n = 1'b0;
      if (byp) begin
         // wrt lands in the same cycle the slave acts on ss_fall
         clks(2);
         tx_data = byp_val;
         wrt     = 1'b1;
         clks(1);
         wrt = 1'b0;
         clks(5);
      end else begin
         clks(8);
      end
      for (int i = 0; i < n; i++) begin
         sclk = 1'b0;
         mosi = (i < 16) ? cmd[15-i] : 1'($urandom);
         if (mid && i == 5) begin
            tx_data = mid_val;
            wrt     = 1'b1;
            clks(1);
            wrt = 1'b0;
            clks(15);
            tx_model = mid_val;
         end else begin
            clks(16);
         end
         if (i < 16) got[15-i] = miso;
         sclk = 1'b1;
         clks(16);
      end
      clks(8);
      e.err = (n != 16);
      e.rx  = (n == 16) ? cmd : rx_model;
      if (n == 16) rx_model = cmd;
      exp_q.push_back(e);
      ss_n = 1'b1;
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) clks(1);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL strobe_timeout: got no strobe expected %s", e.err ? "frm_err" : "cmd_rdy");
         exp_q.delete();
      end
      if (n >= 16) chk("master_rd_data", got, resp);
      clks(8);
   endtask

   // monitor: every strobe must match the oldest expected frame outcome
   always @(negedge clk) begin
      if (!rst && (cmd_rdy || frm_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got cmd_rdy=%b frm_err=%b expected none", cmd_rdy, frm_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_kind", {14'b0, cmd_rdy, frm_err}, e.err ? 16'd1 : 16'd2);
            chk("rx_data_at_strobe", rx_data, e.rx);
         end
      end
   end

   initial begin
      rst      = 1'b1;
      ss_n     = 1'b1;
      sclk     = 1'b1;
      mosi     = 1'b0;
      wrt      = 1'b0;
      tx_data  = '0;
      tx_model = '0;
      rx_model = '0;
      clks(5);
      chk("reset_rx_data", rx_data, 16'h0000);
      chk("reset_strobes", {14'b0, cmd_rdy, frm_err}, 16'd0);
      chk("reset_miso_z", {15'b0, miso === 1'bz}, 16'd1);
      rst = 1'b0;
      clks(5);

      write_tx(16'hA5C3);
      frame(16'h2800, 16, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("rx_after_2800", rx_data, 16'h2800);

      frame(16'h6A1F, 16, 1'b1, 16'h0C05, 1'b0, 16'h0);
      frame(16'h9307, 16, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("rx_back_to_back", rx_data, 16'h9307);

      frame(16'h4C4C, 16, 1'b0, 16'h0, 1'b1, 16'h1234);

      frame(16'hDEAD, 9, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("rx_kept_after_short", rx_data, rx_model);

      for (int k = 0; k < 6; k++) begin
         sclk = 1'b0;
         clks(5);
         sclk = 1'b1;
         clks(5);
      end
      chk("idle_sclk_miso_z", {15'b0, miso === 1'bz}, 16'd1);
      chk("idle_sclk_rx_kept", rx_data, rx_model);
      frame(16'h0F0F, 16, 1'b0, 16'h0, 1'b0, 16'h0);

      write_tx(16'hBEEF);
      @(negedge clk);
      ss_n = 1'b0;
      clks(8);
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b0;
         mosi = i[0];
         clks(16);
         sclk = 1'b1;
         clks(16);
      end
      rst = 1'b1;
      clks(3);
      ss_n = 1'b1;
      sclk = 1'b1;
      clks(3);
      rst      = 1'b0;
      tx_model = '0;
      rx_model = '0;
      clks(4);
      chk("midreset_rx_data", rx_data, 16'h0000);
      chk("midreset_strobes", {14'b0, cmd_rdy, frm_err}, 16'd0);
      chk("midreset_miso_z", {15'b0, miso === 1'bz}, 16'd1);
      frame(16'hFFFF, 16, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("rx_after_reset_frame", rx_data, 16'hFFFF);

      for (int r = 0; r < 25; r++) begin
         int n;
         if ($urandom_range(0, 1) == 1) write_tx(16'($urandom));
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
         frame(16'($urandom), n, $urandom_range(0, 3) == 0, 16'($urandom),
               $urandom_range(0, 4) == 0, 16'($urandom));
      end
      chk("final_rx_data", rx_data, rx_model);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slv16.md
# spi_slv16

16-bit SPI responder (mode 0) that sits on the far end of the SPI_mstr16 link in place of a peripheral model. It samples the master's SS_n/SCLK/MOSI in the local clk domain and shifts a preloaded 16-bit response out on MISO. At frame end it presents the received 16-bit command with a one-cycle ready strobe. It is used as the synthesizable slave for inertial/ADC-style peripherals on the same bus.

## Interface
- FRAME_BITS, 16, bits per transaction; fixed, from package.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  slave select from master, async to clk, active low.
- SCLK  in  1  serial clock from master, async; idles high.
- MOSI  in  1  serial data from master; changes on SCLK fall.
- MISO  out  1  serial data to master; shft_reg[15] while SS_n low, 1'bz otherwise.
- tx_data  in  16  response word for the next frame.
- wrt  in  1  one-cycle strobe; latches tx_data into tx_buf.
- rx_data  out  16  last complete command received.
- cmd_rdy  out  1  one-cycle pulse when rx_data updates.
- frm_err  out  1  one-cycle pulse when a frame ends with bit count != 16.

## Operation
- Inputs SS_n, SCLK and MOSI are each double-flopped, with a third SS_n/SCLK stage for edge detection; ss_fall, ss_rise, sclk_rise and sclk_fall are single-cycle pulses.
- MOSI is taken from the second flop, so it stays aligned with sclk_rise.
- States are IDLE and SHIFT.
- IDLE → SHIFT on ss_fall:
  - shft_reg <= tx_buf; if wrt is high in the same cycle, shft_reg <= tx_data (bypass).
  - bit_cnt <= 0.
- In SHIFT:
  - On sclk_rise: mosi_smpl <= MOSI and bit_cnt++, saturating at 31.
  - On sclk_fall: shft_reg <= {shft_reg[14:0], mosi_smpl}, but only when bit_cnt != 0 and bit_cnt < 16. The idle-high front-porch fall before the first rise does not shift.
- SHIFT → IDLE on ss_rise:
  - If bit_cnt == 16: rx_data <= {shft_reg[14:0], mosi_smpl} and cmd_rdy pulses.
  - Otherwise rx_data is unchanged and frm_err pulses.
- SCLK edges while in IDLE are ignored.
- wrt in any state sets tx_buf <= tx_data. During SHIFT this affects only the next frame; the shift register is never reloaded mid-frame.
- Reset mid-frame: everything returns to reset values and state becomes IDLE. The remainder of the frame is ignored until the next ss_fall.

## Timing
- Reset values:
  - shft_reg, tx_buf, rx_data and mosi_smpl are 0.
  - bit_cnt is 0; cmd_rdy and frm_err are 0; state is IDLE.
  - MISO is high-Z while SS_n is high.
- ss_fall is detected 3 clk after the SS_n pin falls, and MISO is valid on tx_buf[15] at +4 clk.
- The master must hold a front porch of ≥6 clk and keep SCLK high and low phases of ≥4 clk each. SPI_mstr16 supplies 16 clk per phase.
- A SCLK pin edge is acted on 3 clk later. MISO updates 4 clk after the SCLK pin falls, well before the next rise.
- cmd_rdy and frm_err assert 4 clk after the SS_n pin rises, for exactly 1 clk. rx_data is valid in the same cycle and held until the next good frame.
- ss_fall and ss_rise never coincide; a SS_n glitch shorter than 1 clk may be missed.

## Structure
- Package spi_pkg holds:
  - FRAME_BITS = 16;
  - typedef enum logic {IDLE, SHIFT} spi_slv_state_t;
  - SYNC_STAGES = 2.
- Sub-module spi_sync_edge:
  - one async input, synchronized through SYNC_STAGES flops plus an edge flop;
  - outputs sync, rise and fall;
  - instantiated for SS_n and SCLK.
- MOSI uses a plain two-flop synchronizer inside spi_slv16.

## Test plan
- Reset, then wrt with tx_data=16'hA5C3; SPI_mstr16 sends cmd=16'h2800 → rx_data=16'h2800, cmd_rdy pulses once, master rd_data=16'hA5C3.
- Back-to-back frames with wrt of 16'h0C05 issued mid first frame → first frame returns 16'hA5C3, second returns 16'h0C05, and rx_data matches each command.
- wrt with 16'h1234 in the same cycle as ss_fall → that frame returns 16'h1234.
- Bench master sends only 9 SCLK cycles then raises SS_n → frm_err pulses, cmd_rdy stays 0, rx_data keeps its previous value.
- Assert rst after 8 bits of a frame → all outputs return to reset values. The next full frame with cmd=16'hFFFF gives rx_data=16'hFFFF and MISO returns 16'h0000.
- Toggle SCLK with SS_n high → no shift and no strobes, MISO stays high-Z.
